// File: rtl/led_scheduler.sv
// led_scheduler: drives three status LEDs from a shared prescaler tick.
// A two-state FSM (IDLE/RUN) steps the LEDs through a TOGGLE chase,
// ONEHOT chase or ALL group blink, restricted to an enable mask.
// Configuration (tc/mask/mode) is accepted over a valid/ready port in IDLE.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-low reset
//   cfg_valid/ready  config handshake (ready only in IDLE)
//   cfg_tc           terminal count, tick period = cfg_tc+1 cycles
//   cfg_mask         channel enable, bit0=led1 .. bit2=led3
//   cfg_mode         0=TOGGLE, 1=ONEHOT, 2=ALL, 3=TOGGLE
//   start/stop       level-sampled run control (stop has priority)
//   led1..led3       registered LED drives
//   busy             high in RUN
//   tick             high when RUN and count==tc
module led_scheduler #(
  parameter int unsigned      CNT_W      = 32,
  parameter logic [CNT_W-1:0] DEFAULT_TC = CNT_W'(99999999)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_tc,
  input  logic [2:0]       cfg_mask,
  input  logic [1:0]       cfg_mode,
  input  logic             start,
  input  logic             stop,
  output logic             led1,
  output logic             led2,
  output logic             led3,
  output logic             busy,
  output logic             tick
);

  localparam logic [1:0] MODE_ONEHOT = 2'd1;
  localparam logic [1:0] MODE_ALL    = 2'd2;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [1:0]       r_ptr;
  logic [1:0]       w_ptr_nxt;
  logic [2:0]       r_leds;
  logic [2:0]       w_leds_nxt;
  logic [CNT_W-1:0] r_tc;
  logic [2:0]       r_mask;
  logic [1:0]       r_mode;
  logic             w_cfg_load;
  logic             w_tick;

  // Lowest enabled channel; 0 when nothing is enabled.
  function automatic logic [1:0] f_first_ptr(input logic [2:0] mask);
    logic [1:0] p;
    p = 2'd0;
    if (mask[2]) p = 2'd2;
    if (mask[1]) p = 2'd1;
    if (mask[0]) p = 2'd0;
    return p;
  endfunction

  // Next enabled channel in cyclic order 0->1->2->0; stays put if none other.
  function automatic logic [1:0] f_next_ptr(input logic [1:0] ptr, input logic [2:0] mask);
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] p;
    c1 = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    p  = ptr;
    if (mask[c2]) p = c2;
    if (mask[c1]) p = c1;
    return p;
  endfunction

  assign w_tick    = (r_state == S_RUN) && (r_count == r_tc);
  assign tick      = w_tick;
  assign busy      = (r_state == S_RUN);
  assign cfg_ready = (r_state == S_IDLE);
  assign led1      = r_leds[0];
  assign led2      = r_leds[1];
  assign led3      = r_leds[2];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; stop beats start.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && !stop) w_state_nxt = S_RUN;
      S_RUN:   if (stop)           w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values: counter, pointer, LEDs and config load.
  always_comb begin
    w_count_nxt = r_count;
    w_ptr_nxt   = r_ptr;
    w_leds_nxt  = r_leds;
    w_cfg_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_count_nxt = '0;
        w_cfg_load  = cfg_valid;
        if (start && !stop) begin
          w_leds_nxt = 3'b000;
          w_ptr_nxt  = f_first_ptr(r_mask);
        end
      end
      S_RUN: begin
        if (stop) begin
          w_count_nxt = '0;
          w_leds_nxt  = 3'b000;
        end else begin
          w_count_nxt = w_tick ? '0 : r_count + CNT_W'(1);
          // An empty mask freezes leds and ptr, the tick keeps running.
          if (w_tick && (r_mask != 3'b000)) begin
            case (r_mode)
              MODE_ONEHOT: begin
                w_leds_nxt = 3'b001 << r_ptr;
                w_ptr_nxt  = f_next_ptr(r_ptr, r_mask);
              end
              MODE_ALL: w_leds_nxt = r_leds ^ r_mask;
              default: begin
                w_leds_nxt[r_ptr] = ~r_leds[r_ptr];
                w_ptr_nxt         = f_next_ptr(r_ptr, r_mask);
              end
            endcase
          end
        end
      end
      default: begin
        w_count_nxt = '0;
        w_leds_nxt  = 3'b000;
      end
    endcase
  end

  // Datapath and config registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_ptr   <= 2'd0;
      r_leds  <= 3'b000;
      r_tc    <= DEFAULT_TC;
      r_mask  <= 3'b111;
      r_mode  <= 2'd0;
    end else begin
      r_count <= w_count_nxt;
      r_ptr   <= w_ptr_nxt;
      r_leds  <= w_leds_nxt;
      if (w_cfg_load) begin
        r_tc   <= cfg_tc;
        r_mask <= cfg_mask;
        r_mode <= cfg_mode;
      end
    end
  end

endmodule

// File: tb/tb_led_scheduler.sv
// Testbench for led_scheduler: directed scenarios plus random run/stop/config
// traffic, compared each cycle against a tick-count based reference model.
module tb_led_scheduler;

  localparam int unsigned CNT_W  = 32;
  localparam logic [31:0] DEF_TC = 32'd99999999;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_tc;
  logic [2:0]       cfg_mask;
  logic [1:0]       cfg_mode;
  logic             start;
  logic             stop;
  logic             led1, led2, led3;
  logic             busy;
  logic             tick;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: run flag, cycles elapsed since the start edge, config.
  logic        m_run;
  longint      m_k;
  logic [31:0] m_tc;
  logic [2:0]  m_mask;
  logic [1:0]  m_mode;

  always #5 clk = ~clk;

  led_scheduler #(.CNT_W(CNT_W), .DEFAULT_TC(DEF_TC)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_tc(cfg_tc), .cfg_mask(cfg_mask), .cfg_mode(cfg_mode),
    .start(start), .stop(stop),
    .led1(led1), .led2(led2), .led3(led3),
    .busy(busy), .tick(tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // LED pattern after n ticks: enabled channels form an ordered list, tick j
  // acts on list entry j mod L.
  function automatic logic [2:0] f_exp_leds(input longint n, input logic [2:0] mk,
                                            input logic [1:0] md);
    int ch[3];
    int len;
    logic [2:0] r;
    longint hits;
    len = 0;
    r   = 3'b000;
    for (int i = 0; i < 3; i++) if (mk[i]) begin ch[len] = i; len++; end
    if (len == 0 || n == 0) return 3'b000;
    case (md)
      2'd1: r[ch[int'((n - 1) % len)]] = 1'b1;
      2'd2: r = n[0] ? mk : 3'b000;
      default: begin
        for (int p = 0; p < len; p++) begin
          hits = n / len + (((n % len) > p) ? 1 : 0);
          if (hits[0]) r[ch[p]] = 1'b1;
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic f_exp_tick();
    return m_run && ((m_k % (longint'(m_tc) + 1)) == longint'(m_tc));
  endfunction

  function automatic logic [2:0] f_exp_out();
    return m_run ? f_exp_leds(m_k / (longint'(m_tc) + 1), m_mask, m_mode) : 3'b000;
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_k = 0; m_tc = DEF_TC; m_mask = 3'b111; m_mode = 2'd0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] t, input logic [2:0] mk,
                            input logic [1:0] md, input logic st, input logic sp);
    if (!m_run) begin
      if (v) begin m_tc = t; m_mask = mk; m_mode = md; end
      if (st && !sp) begin m_run = 1'b1; m_k = 0; end
    end else if (sp) begin
      m_run = 1'b0; m_k = 0;
    end else begin
      m_k++;
    end
  endtask

  task automatic check_outputs();
    check("leds", 32'({led3, led2, led1}), 32'(f_exp_out()));
    check("tick", 32'(tick), 32'(f_exp_tick()));
    check("busy", 32'(busy), 32'(m_run));
    check("cfg_ready", 32'(cfg_ready), 32'(!m_run));
  endtask

  // One clock: check current outputs, drive inputs, advance model on the edge.
  task automatic cycle(input logic v, input logic [31:0] t, input logic [2:0] mk,
                       input logic [1:0] md, input logic st, input logic sp);
    check_outputs();
    cfg_valid = v; cfg_tc = t; cfg_mask = mk; cfg_mode = md; start = st; stop = sp;
    @(posedge clk);
    model_step(v, t, mk, md, st, sp);
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic idle();     cycle(1'b0, '0, 3'b000, 2'd0, 1'b0, 1'b0); endtask
  task automatic do_start(); cycle(1'b0, '0, 3'b000, 2'd0, 1'b1, 1'b0); endtask
  task automatic do_stop();  cycle(1'b0, '0, 3'b000, 2'd0, 1'b0, 1'b1); endtask
  task automatic do_cfg(input logic [31:0] t, input logic [2:0] mk, input logic [1:0] md);
    cycle(1'b1, t, mk, md, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; cfg_valid = 1'b0; cfg_tc = '0; cfg_mask = 3'b000; cfg_mode = 2'd0;
    start = 1'b0; stop = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
    idle();

    // Default config: no LED change for 1000 cycles.
    do_start();
    repeat (1000) idle();
    check("dflt_leds", 32'({led3, led2, led1}), 32'h0);
    check("dflt_busy", 32'(busy), 32'h1);
    do_stop();

    // TOGGLE chase, tc=3, all channels.
    do_cfg(32'd3, 3'b111, 2'd0);
    do_start();
    for (int e = 1; e <= 16; e++) begin
      if (e % 4 == 0) check("tgl_tick", 32'(tick), 32'h1);
      idle();
      if (e == 4)  check("tgl_e4",  32'({led3, led2, led1}), 32'h1);
      if (e == 8)  check("tgl_e8",  32'({led3, led2, led1}), 32'h3);
      if (e == 12) check("tgl_e12", 32'({led3, led2, led1}), 32'h7);
      if (e == 16) check("tgl_e16", 32'({led3, led2, led1}), 32'h6);
    end
    do_stop();

    // ONEHOT with led2 masked off.
    do_cfg(32'd1, 3'b101, 2'd1);
    do_start();
    for (int e = 1; e <= 8; e++) begin
      idle();
      check("oh_led2", 32'(led2), 32'h0);
      if (e % 2 == 0)
        check("oh_seq", 32'({led3, led2, led1}), (e % 4 == 2) ? 32'h1 : 32'h4);
    end
    do_stop();

    // ALL blink, tc=0: tick every cycle.
    do_cfg(32'd0, 3'b011, 2'd2);
    do_start();
    for (int e = 1; e <= 8; e++) begin
      check("all_tick", 32'(tick), 32'h1);
      idle();
      check("all_leds", 32'({led3, led2, led1}), (e % 2 == 1) ? 32'h3 : 32'h0);
    end

    // Stop on a tick cycle, then start+stop together in IDLE.
    check("stop_tick", 32'(tick), 32'h1);
    do_stop();
    check("stop_leds", 32'({led3, led2, led1}), 32'h0);
    check("stop_busy", 32'(busy), 32'h0);
    cycle(1'b0, '0, 3'b000, 2'd0, 1'b1, 1'b1);
    check("ss_busy", 32'(busy), 32'h0);

    // Config stalled while running, accepted on the first IDLE edge.
    do_cfg(32'd2, 3'b111, 2'd0);
    do_start();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'd0, 3'b001, 2'd2, 1'b0, 1'b0);
      check("stall_rdy", 32'(cfg_ready), 32'h0);
    end
    cycle(1'b1, 32'd0, 3'b001, 2'd2, 1'b0, 1'b1);
    check("stall_rdy_back", 32'(cfg_ready), 32'h1);
    cycle(1'b1, 32'd0, 3'b001, 2'd2, 1'b0, 1'b0);
    do_start();
    idle();
    check("stall_newcfg", 32'({led3, led2, led1}), 32'h1);
    repeat (3) idle();

    // Asynchronous reset between edges while running.
    do_stop();
    do_cfg(32'd0, 3'b111, 2'd1);
    do_start();
    repeat (3) idle();
    #2 rst = 1'b0;
    #1 model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    do_start();
    for (int i = 0; i < 5; i++) begin
      idle();
      check("rst_dflt_leds", 32'({led3, led2, led1}), 32'h0);
    end
    do_stop();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic v, st, sp;
      logic [31:0] t;
      logic [2:0] mk;
      logic [1:0] md;
      t  = 32'($urandom_range(4, 0));
      mk = 3'($urandom);
      md = 2'($urandom);
      if (!m_run) begin
        v  = ($urandom_range(3, 0) == 0);
        st = !v && ($urandom_range(5, 0) == 0);
        sp = ($urandom_range(9, 0) == 0);
      end else begin
        v  = ($urandom_range(3, 0) == 0);
        st = ($urandom_range(3, 0) == 0);
        sp = ($urandom_range(24, 0) == 0);
      end
      cycle(v, t, mk, md, st, sp);
    end
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
